// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports and memory-side bus shared by the arbiter
interface mem_arbiter_if #(parameter int DW = 16, parameter int AW = 16);
  logic          req0, we0, gnt0, rvalid0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] adr0, adr1, mem_adr;
  logic [DW-1:0] wd0, rd0, wd1, rd1, mem_wd, mem_rd;
  logic          mem_we;
  modport master (
    output req0, we0, adr0, wd0, req1, we1, adr1, wd1, mem_rd,
    input  gnt0, rd0, rvalid0, gnt1, rd1, rvalid1, mem_we, mem_adr, mem_wd
  );
  modport slave (
    input  req0, we0, adr0, wd0, req1, we1, adr1, wd1, mem_rd,
    output gnt0, rd0, rvalid0, gnt1, rd1, rvalid1, mem_we, mem_adr, mem_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, burst-bounded sharing of one sync-read memory between CPU and loader ports
module mem_arbiter #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last, last_nx, rv0, rv1, g0, g1;
  // reset masks grants and read-valids in the very cycle it is asserted
  assign g0 = state == OWN0 && bus.req0 && !reset;
  assign g1 = state == OWN1 && bus.req1 && !reset;
  assign bus.gnt0    = g0;
  assign bus.gnt1    = g1;
  assign bus.mem_we  = g0 ? bus.we0 : g1 ? bus.we1 : 1'b0;
  assign bus.mem_adr = g0 ? bus.adr0 : g1 ? bus.adr1 : {AW{1'b0}};
  assign bus.mem_wd  = g0 ? bus.wd0 : g1 ? bus.wd1 : {DW{1'b0}};
  assign bus.rvalid0 = rv0 && !reset;
  assign bus.rvalid1 = rv1 && !reset;
  assign bus.rd0     = bus.rvalid0 ? bus.mem_rd : {DW{1'b0}};
  assign bus.rd1     = bus.rvalid1 ? bus.mem_rd : {DW{1'b0}};
  // state, burst counter, last owner and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
      rv0   <= g0 && !bus.we0;
      rv1   <= g1 && !bus.we1;
    end
  end
  // ownership transitions: idle arbitration, owner release and burst expiry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    case (state)
      IDLE: if (bus.req0 || bus.req1) begin
        state_nx = (bus.req0 && (!bus.req1 || last)) ? OWN0 : OWN1;
        cnt_nx   = '0;
      end
      OWN0: if (!bus.req0) begin
        state_nx = bus.req1 ? OWN1 : IDLE;
        last_nx  = 1'b0;
        cnt_nx   = '0;
      end else if (cnt == LAST_BEAT) begin
        cnt_nx   = '0;
        state_nx = bus.req1 ? OWN1 : OWN0;
        last_nx  = bus.req1 ? 1'b0 : last;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
      OWN1: if (!bus.req1) begin
        state_nx = bus.req0 ? OWN0 : IDLE;
        last_nx  = 1'b1;
        cnt_nx   = '0;
      end else if (cnt == LAST_BEAT) begin
        cnt_nx   = '0;
        state_nx = bus.req0 ? OWN0 : OWN1;
        last_nx  = bus.req0 ? 1'b1 : last;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for bursts, streaming, reset and handoff
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  mem_arbiter_if #(.DW(16), .AW(16)) bus ();
  mem_arbiter #(.DW(16), .AW(16), .MAX_BURST(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] mem [256] = '{80: 16'h1234, default: 16'h0000};
  // synchronous-read memory model
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_adr[7:0]] <= bus.mem_wd;
    bus.mem_rd <= mem[bus.mem_adr[7:0]];
  end
  typedef struct {
    logic [31:0] rst, r0, w0, a0, d0, r1, w1, a1, d1;
    logic [31:0] g0, g1, mw, ma, md, v0, q0, v1, q1;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.adr0 = '0; bus.wd0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.adr1 = '0; bus.wd1 = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    clear();
    step();
    reset = 1'b0;
  endtask
  initial begin
    clear();
    tbl = '{
      '{1, 0,0,0,0,    0,0,0,0,   0,0,0,0,0,   0,0,0,0},
      '{0, 1,1,84,7,   0,0,0,0,   0,0,0,0,0,   0,0,0,0},
      '{0, 1,1,84,7,   0,0,0,0,   1,0,1,84,7,  0,0,0,0},
      '{0, 0,0,0,0,    1,0,80,0,  0,0,0,0,0,   0,0,0,0},
      '{0, 0,0,0,0,    1,0,80,0,  0,1,0,80,0,  0,0,0,0},
      '{0, 0,0,0,0,    0,0,0,0,   0,0,0,0,0,   0,0,1,'h1234},
      '{0, 1,0,84,0,   0,0,0,0,   0,0,0,0,0,   0,0,0,0},
      '{0, 1,0,84,0,   0,0,0,0,   1,0,0,84,0,  0,0,0,0},
      '{0, 0,0,0,0,    0,0,0,0,   0,0,0,0,0,   1,7,0,0},
      '{0, 0,0,0,0,    0,0,0,0,   0,0,0,0,0,   0,0,0,0}
    };
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst[0];
      bus.req0 = tbl[i].r0[0]; bus.we0 = tbl[i].w0[0]; bus.adr0 = tbl[i].a0[15:0]; bus.wd0 = tbl[i].d0[15:0];
      bus.req1 = tbl[i].r1[0]; bus.we1 = tbl[i].w1[0]; bus.adr1 = tbl[i].a1[15:0]; bus.wd1 = tbl[i].d1[15:0];
      #3;
      chk($sformatf("v%0d.gnt0", i), 32'(bus.gnt0), tbl[i].g0);
      chk($sformatf("v%0d.gnt1", i), 32'(bus.gnt1), tbl[i].g1);
      chk($sformatf("v%0d.mem_we", i), 32'(bus.mem_we), tbl[i].mw);
      chk($sformatf("v%0d.mem_adr", i), 32'(bus.mem_adr), tbl[i].ma);
      chk($sformatf("v%0d.mem_wd", i), 32'(bus.mem_wd), tbl[i].md);
      chk($sformatf("v%0d.rvalid0", i), 32'(bus.rvalid0), tbl[i].v0);
      chk($sformatf("v%0d.rd0", i), 32'(bus.rd0), tbl[i].q0);
      chk($sformatf("v%0d.rvalid1", i), 32'(bus.rvalid1), tbl[i].v1);
      chk($sformatf("v%0d.rd1", i), 32'(bus.rd1), tbl[i].q1);
      step();
    end
    do_reset();
    for (int c = 0; c < 13; c++) begin
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 16'(c);       bus.wd0 = 16'(c);
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 16'(100 + c); bus.wd1 = 16'(c);
      #3;
      chk($sformatf("rr%0d.gnt", c), 32'({bus.gnt1, bus.gnt0}),
          c == 0 ? 32'd0 : (((c - 1) / 4) % 2 == 0 ? 32'd1 : 32'd2));
      step();
    end
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 16'(200 + c); bus.wd0 = 16'(c);
      bus.req1 = 1'b0; bus.we1 = 1'b1; bus.adr1 = 16'd30;
      #3;
      chk($sformatf("lone%0d.gnt0", c), 32'(bus.gnt0), 32'(c > 0));
      chk($sformatf("lone%0d.gnt1", c), 32'(bus.gnt1), 32'd0);
      chk($sformatf("lone%0d.mem_adr", c), 32'(bus.mem_adr), c > 0 ? 32'(200 + c) : 32'd0);
      step();
    end
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 16'd80;
    #3;
    chk("rst.idle_gnt0", 32'(bus.gnt0), 32'd0);
    step();
    #3;
    chk("rst.beat_gnt0", 32'(bus.gnt0), 32'd1);
    step();
    reset = 1'b1;
    #3;
    chk("rst.gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst.rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst.rd0", 32'(bus.rd0), 32'd0);
    chk("rst.mem_adr", 32'(bus.mem_adr), 32'd0);
    step();
    reset = 1'b0;
    #3;
    chk("rst.after_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst.after_rvalid0", 32'(bus.rvalid0), 32'd0);
    step();
    #3;
    chk("rst.regrant_gnt0", 32'(bus.gnt0), 32'd1);
    step();
    bus.req0 = 1'b0;
    #3;
    chk("rst.rvalid0_back", 32'(bus.rvalid0), 32'd1);
    chk("rst.rd0_back", 32'(bus.rd0), 32'h1234);
    step();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.req0 = c < 3; bus.we0 = 1'b1; bus.adr0 = 16'd10; bus.wd0 = 16'd1;
      bus.req1 = 1'b1;  bus.we1 = 1'b1; bus.adr1 = 16'd20; bus.wd1 = 16'd2;
      #3;
      chk($sformatf("ho%0d.gnt0", c), 32'(bus.gnt0), 32'(c == 1 || c == 2));
      chk($sformatf("ho%0d.gnt1", c), 32'(bus.gnt1), 32'(c >= 4));
      chk($sformatf("ho%0d.mem_we", c), 32'(bus.mem_we), 32'(c != 0 && c != 3));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
